// File: rtl/bfly_pair_feeder.sv
// bfly_pair_feeder: buffers the first half of each N-point frame and then
// pairs every second-half sample x[k+N/2] with its stored partner x[k],
// presenting both operands plus the twiddle index to a radix-2 butterfly.
module bfly_pair_feeder #(
    parameter int unsigned float_len = 32,
    parameter int unsigned half_log2 = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_sync,
    input  logic [2*float_len-1:0]   data_in,
    input  logic                     data_in_valid,
    output logic [2*float_len-1:0]   data_out1,
    output logic [2*float_len-1:0]   data_out2,
    output logic                     data_out_valid,
    output logic [half_log2-1:0]     pair_idx,
    output logic                     frame_done
);

    localparam int unsigned W    = 2 * float_len;
    localparam int unsigned HALF = 1 << half_log2;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] PAIR = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [half_log2:0]   cnt_q, cnt_d;
    logic [W-1:0]         mem_q [HALF];

    logic                 wr_en;
    logic [half_log2-1:0] wr_addr;
    logic [half_log2-1:0] k;
    logic                 last;

    logic [W-1:0]         out1_q, out1_d;
    logic [W-1:0]         out2_q, out2_d;
    logic [half_log2-1:0] idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    assign k    = cnt_q[half_log2-1:0];
    assign last = (k == '1);

    // Next-state decode: resync has priority, then fill or pair per state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = k;
        out1_d  = out1_q;
        out2_d  = out2_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (data_in_valid) begin
            if (frame_sync) begin
                // Resync sample becomes index 0 of a fresh frame, no pair output.
                wr_en    = 1'b1;
                wr_addr  = '0;
                cnt_d    = '0;
                cnt_d[0] = 1'b1;
                state_d  = FILL;
            end else if (state_q == FILL) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = PAIR;
                end
            end else begin
                out1_d  = mem_q[k];
                out2_d  = data_in;
                idx_d   = k;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    done_d  = 1'b1;
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // First-half sample buffer; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign data_out1      = out1_q;
    assign data_out2      = out2_q;
    assign pair_idx       = idx_q;
    assign data_out_valid = valid_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_bfly_pair_feeder.sv
// Testbench for bfly_pair_feeder: ramp vector table, directed gap / resync /
// reset sequences, and a long randomized run against a frame-level model.
module tb_bfly_pair_feeder;

    localparam int FL   = 32;
    localparam int HL   = 4;
    localparam int W    = 2 * FL;
    localparam int HALF = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_sync = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          data_in_valid = 1'b0;
    logic [W-1:0]  data_out1, data_out2;
    logic          data_out_valid;
    logic [HL-1:0] pair_idx;
    logic          frame_done;

    bfly_pair_feeder #(.float_len(FL), .half_log2(HL)) dut (
        .clk(clk), .rst(rst), .frame_sync(frame_sync), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_out1(data_out1),
        .data_out2(data_out2), .data_out_valid(data_out_valid),
        .pair_idx(pair_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Frame-level reference: remember the first half, pair the second half.
    logic [W-1:0]  m_frame [HALF];
    int            m_pos = 0;
    logic [W-1:0]  e_o1 = '0, e_o2 = '0;
    logic [HL-1:0] e_idx = '0;
    logic          e_v = 1'b0, e_done = 1'b0;
    int            strobes = 0, dones = 0;

    task automatic model_reset();
        m_pos = 0; e_o1 = '0; e_o2 = '0; e_idx = '0; e_v = 1'b0; e_done = 1'b0;
    endtask

    task automatic model_apply(input logic v, input logic s, input logic [W-1:0] d);
        e_v = 1'b0; e_done = 1'b0;
        if (v) begin
            if (s) m_pos = 0;
            if (m_pos < HALF) begin
                m_frame[m_pos] = d;
                m_pos++;
            end else begin
                e_o1   = m_frame[m_pos - HALF];
                e_o2   = d;
                e_idx  = HL'(m_pos - HALF);
                e_v    = 1'b1;
                e_done = (m_pos == 2 * HALF - 1);
                m_pos  = (m_pos == 2 * HALF - 1) ? 0 : m_pos + 1;
            end
        end
    endtask

    task automatic check(input string name);
        vectors++;
        if (data_out_valid !== e_v || frame_done !== e_done || pair_idx !== e_idx ||
            data_out1 !== e_o1 || data_out2 !== e_o2) begin
            errors++;
            $display("FAIL %s: got v=%b done=%b idx=%0d o1=%h o2=%h, want v=%b done=%b idx=%0d o1=%h o2=%h",
                     name, data_out_valid, frame_done, pair_idx, data_out1, data_out2,
                     e_v, e_done, e_idx, e_o1, e_o2);
        end
        if (data_out_valid === 1'b1) strobes++;
        if (frame_done === 1'b1) dones++;
    endtask

    // One clock: drive, advance, update the model, compare after the edge.
    task automatic step(input logic v, input logic s, input logic [W-1:0] d, input string name);
        data_in_valid = v; frame_sync = s; data_in = d;
        @(posedge clk); #1;
        model_apply(v, s, d);
        check(name);
    endtask

    function automatic logic [W-1:0] cplx(input int re);
        logic [W-1:0] r;
        r = '0;
        r[W-1:FL] = FL'(re);
        return r;
    endfunction

    typedef struct {
        logic          v;
        logic          s;
        logic [W-1:0]  d;
        logic          ev;
        logic          ed;
        logic [HL-1:0] eidx;
        logic [W-1:0]  eo1;
        logic [W-1:0]  eo2;
    } vec_t;

    vec_t tbl [33];

    initial begin
        // Ramp table built from the pairing rule: x[k] with x[k+16], k = i-16.
        for (int i = 0; i < 32; i++) begin
            tbl[i].v = 1'b1;
            tbl[i].s = (i == 0);
            tbl[i].d = cplx(i);
            tbl[i].ev = (i >= 16);
            tbl[i].ed = (i == 31);
            tbl[i].eidx = (i >= 16) ? HL'(i - 16) : '0;
            tbl[i].eo1 = (i >= 16) ? cplx(i - 16) : '0;
            tbl[i].eo2 = (i >= 16) ? cplx(i) : '0;
        end
        tbl[32].v = 1'b0; tbl[32].s = 1'b1; tbl[32].d = cplx(99);
        tbl[32].ev = 1'b0; tbl[32].ed = 1'b0; tbl[32].eidx = 4'd15;
        tbl[32].eo1 = cplx(15); tbl[32].eo2 = cplx(31);

        // Reset state
        #12;
        model_reset();
        check("reset");
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Continuous ramp from the table
        for (int i = 0; i < 33; i++) begin
            data_in_valid = tbl[i].v; frame_sync = tbl[i].s; data_in = tbl[i].d;
            @(posedge clk); #1;
            model_apply(tbl[i].v, tbl[i].s, tbl[i].d);
            e_v = tbl[i].ev; e_done = tbl[i].ed; e_idx = tbl[i].eidx;
            e_o1 = tbl[i].eo1; e_o2 = tbl[i].eo2;
            check("ramp");
        end

        // Gapped frame: valid every third cycle
        strobes = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, i == 0, cplx(100 + i), "gap_valid");
            step(1'b0, 1'b0, cplx(7), "gap_idle1");
            step(1'b0, 1'b1, cplx(8), "gap_idle2");
        end
        vectors++;
        if (strobes != 16) begin
            errors++;
            $display("FAIL gap_strobes: got %0d want 16", strobes);
        end

        // Three back-to-back frames
        strobes = 0; dones = 0;
        for (int i = 0; i < 96; i++) begin
            step(1'b1, (i % 32) == 0, cplx(1000 + i), "b2b");
            if ((i % 32) == 31) begin
                vectors++;
                if (frame_done !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_done: at output %0d got %b want 1", i + 1, frame_done);
                end
            end
        end
        step(1'b0, 1'b0, '0, "b2b_tail");
        vectors++;
        if (strobes != 48 || dones != 3) begin
            errors++;
            $display("FAIL b2b_counts: got %0d strobes %0d dones want 48 3", strobes, dones);
        end

        // Resync at sample 20
        strobes = 0;
        for (int i = 0; i < 20; i++) step(1'b1, i == 0, cplx(2000 + i), "resync_pre");
        vectors++;
        if (strobes != 4) begin
            errors++;
            $display("FAIL resync_pairs: got %0d want 4", strobes);
        end
        strobes = 0;
        for (int i = 0; i < 16; i++) step(1'b1, i == 0, cplx(3000 + i), "resync_fill");
        vectors++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL resync_quiet: got %0d want 0", strobes);
        end
        for (int i = 16; i < 32; i++) step(1'b1, 1'b0, cplx(3000 + i), "resync_pair");
        vectors++;
        if (strobes != 16) begin
            errors++;
            $display("FAIL resync_newframe: got %0d want 16", strobes);
        end

        // Reset pulse at sample 24
        for (int i = 0; i < 24; i++) step(1'b1, i == 0, cplx(4000 + i), "rst_pre");
        rst = 1'b0; #1;
        model_reset();
        check("rst_async");
        @(posedge clk); #1;
        check("rst_held");
        rst = 1'b1;
        step(1'b0, 1'b0, '0, "rst_release");
        strobes = 0;
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, cplx(5000 + i), "rst_frame");
        vectors++;
        if (strobes != 16) begin
            errors++;
            $display("FAIL rst_frame_pairs: got %0d want 16", strobes);
        end

        // Randomized: 1000 frames, random data and gaps, occasional resync
        for (int f = 0; f < 1000; f++) begin
            int i;
            i = 0;
            while (i < 32) begin
                if ($urandom_range(3) != 0) begin
                    logic s;
                    s = (i == 0) || ($urandom_range(199) == 0);
                    step(1'b1, s, {$urandom, $urandom}, "random");
                    i = s ? 1 : i + 1;
                end else begin
                    step(1'b0, 1'($urandom_range(1)), {$urandom, $urandom}, "random_gap");
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bfly_pair_feeder.md
BFLY_PAIR_FEEDER -- requirements
Module: bfly_pair_feeder

Interface
REQ-001 Parameter float_len, default 32: width of one float32 component; a complex word is 2*float_len bits, real in the upper half, imaginary in the lower half.
REQ-002 Parameter half_log2, default 4: log2 of N/2, where N is the frame length; N/2 = 2^half_log2 = 16 by default.
REQ-003 Port clk  input  1  sole clock; all state is updated on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-low.
REQ-005 Port frame_sync  input  1  frame restart marker, sampled only when data_in_valid = 1.
REQ-006 Port data_in  input  2*float_len  serial complex sample.
REQ-007 Port data_in_valid  input  1  data_in is valid this cycle; gaps of any length are allowed.
REQ-008 Port data_out1  output  2*float_len  butterfly operand x[k], upper-half-of-frame partner excluded.
REQ-009 Port data_out2  output  2*float_len  butterfly operand x[k+N/2].
REQ-010 Port data_out_valid  output  1  one-cycle strobe: the data_out1/data_out2 pair is valid.
REQ-011 Port pair_idx  output  half_log2  k of the current pair, used as the twiddle address by the downstream stage.
REQ-012 Port frame_done  output  1  one-cycle strobe coincident with the last pair of a frame (k = N/2-1).

Function
REQ-013 The block shall hold a buffer of N/2 complex words, a sample counter cnt[half_log2:0], and a two-state FSM with states FILL and PAIR.
REQ-014 FILL (cnt < N/2): each valid sample shall be written to buf[cnt[half_log2-1:0]], cnt shall increment, and no output strobe shall occur.
REQ-015 FILL -> PAIR shall occur on the valid sample that writes address N/2-1.
REQ-016 PAIR: each valid sample x with k = cnt[half_log2-1:0] shall produce, on the next rising edge, data_out1 = buf[k], data_out2 = x, pair_idx = k, and data_out_valid = 1 for exactly one cycle.
REQ-017 Latency shall be exactly 1 clock from a PAIR-phase input sample to its output pair.
REQ-018 PAIR -> FILL shall occur on the valid sample at k = N/2-1; that output cycle shall also assert frame_done = 1; cnt shall wrap to 0.
REQ-019 Back-to-back frames with no idle cycle shall be supported; the first sample of the next frame shall be written to buf[0] while the final pair of the current frame is output.
REQ-020 When data_in_valid = 0, cnt, the FSM and buf shall hold; data_out_valid and frame_done shall be 0 the following cycle.
REQ-021 data_out1, data_out2 and pair_idx shall hold their last values while data_out_valid = 0.
REQ-022 When frame_sync = 1 and data_in_valid = 1 in the same cycle, that sample shall be treated as index 0 of a new frame: it is written to buf[0], cnt becomes 1, the state becomes FILL, and any partial frame is discarded with no pair output for that sample, in either state.
REQ-023 When frame_sync = 1 and data_in_valid = 0, frame_sync shall be ignored.
REQ-024 No arithmetic shall be performed on sample data; words shall pass bit-exact.
REQ-025 No backpressure shall exist; the downstream butterfly shall accept every data_out_valid strobe.

Reset
REQ-026 While rst = 0, asynchronously: cnt = 0, state = FILL, data_out_valid = 0, frame_done = 0, data_out1 = 0, data_out2 = 0, pair_idx = 0.
REQ-027 Buffer contents shall not be reset; they shall be unobservable until rewritten.
REQ-028 Reset asserted mid-frame shall discard the partial frame; the first valid sample after rst returns to 1 shall be index 0.
REQ-029 Release of rst shall be synchronous-safe: the first active edge shall occur no earlier than one clk after rst rises.

Verification
REQ-030 Continuous ramp: 32 valid samples, real part = i, imaginary part = 0, frame_sync on i = 0 -> 16 strobes, each with data_out1.re = k, data_out2.re = k+16, pair_idx = k, at input cycle + 1; frame_done only at k = 15.
REQ-031 Gapped input: valid asserted every third cycle for one frame -> same 16 pairs, each 1 cycle after its second-half sample; no strobes in the gaps.
REQ-032 Three back-to-back frames, 96 samples, no idle cycles -> 48 strobes, pairs correct per frame, frame_done at output cycles 32, 64 and 96.
REQ-033 frame_sync asserted at sample 20 of a frame -> pairs k = 0..3 emitted, then no further strobes until 16 more samples after the restart; the new frame pairs from buf[0] = the resync sample.
REQ-034 rst pulsed low for 1 cycle at sample 24 of a frame -> outputs go to 0 immediately; the next 32 samples produce one clean frame with pair_idx 0..15.
REQ-035 Random data and random valid gaps over 1000 frames -> output matches the scoreboard pairs (x[k], x[k+16]) bit-exact.
